// File: rtl/sync_fifo_ext.sv
// sync_fifo_ext -- single-clock FIFO with selectable read mode and status flags.
//
// Parameters
//   DATA_WIDTH  data word width in bits
//   DEPTH       number of entries (power of two, >= 2)
//   FWFT        0: registered read (data_out updates one edge after an
//                  accepted read); 1: first-word-fall-through (head entry is
//                  presented on data_out whenever the FIFO is not empty)
//   AF_LEVEL    almost_full asserts when count >= AF_LEVEL   (1..DEPTH)
//   AE_LEVEL    almost_empty asserts when count <= AE_LEVEL  (0..DEPTH-1)
//
// Ports
//   clk, rst_n           rising-edge clock, synchronous active-low reset
//   cs                   chip select; with cs=0 nothing changes at all
//   wr_en, data_in       write request and data
//   rd_en, data_out      read request and data
//   clr_err              clears the sticky overflow/underflow flags
//   empty, full          occupancy is 0 / DEPTH
//   almost_empty/full    occupancy threshold flags
//   count                occupancy, 0..DEPTH
//   overflow, underflow  sticky: a write / read request was rejected
//
// All status outputs are decoded from registered state only, so there is no
// combinational path from cs/wr_en/rd_en to any flag.

module sync_fifo_ext #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int FWFT       = 0,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cs,
    input  logic                      wr_en,
    input  logic                      rd_en,
    input  logic                      clr_err,
    input  logic [DATA_WIDTH-1:0]     data_in,
    output logic [DATA_WIDTH-1:0]     data_out,
    output logic                      empty,
    output logic                      full,
    output logic                      almost_empty,
    output logic                      almost_full,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int AW = $clog2(DEPTH);

    // Thresholds narrowed to the count width (both legal ranges fit in AW+1 bits).
    localparam logic [AW:0] AF_THR = AF_LEVEL[AW:0];
    localparam logic [AW:0] AE_THR = AE_LEVEL[AW:0];

    // Decoded operation for the current cycle.
    typedef struct packed {
        logic rd;   // read accepted
        logic wr;   // write accepted
    } fifo_op_t;

    fifo_op_t op;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [AW:0]           wptr_q, wptr_d;
    logic [AW:0]           rptr_q, rptr_d;
    logic [AW:0]           count_q, count_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;

    // Storage is deliberately not reset; stale contents are masked by the
    // pointers (FWFT) or by the reset value of dout_q (registered mode).
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] head;

    logic empty_w, full_w;

    // Pointer MSBs differ only when the write pointer has lapped the read
    // pointer, which distinguishes full from empty at equal low bits.
    assign empty_w = (wptr_q == rptr_q);
    assign full_w  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

    assign head = mem_q[rptr_q[AW-1:0]];

    // ------------------------------------------------------------------
    // Accept logic
    // ------------------------------------------------------------------
    always_comb begin
        op    = '0;
        op.rd = cs & rd_en & ~empty_w;
        // A read in the same cycle frees the slot, so a full FIFO still
        // accepts a write when it is also being read.
        op.wr = cs & wr_en & (~full_w | op.rd);
    end

    // ------------------------------------------------------------------
    // Next-state
    // ------------------------------------------------------------------
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        dout_d  = dout_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;

        if (op.wr) wptr_d = wptr_q + 1'b1;
        if (op.rd) rptr_d = rptr_q + 1'b1;

        case ({op.wr, op.rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Registered-mode read data; in FWFT mode data_out bypasses this
        // register, which is then simply unobserved.
        if (op.rd) dout_d = head;

        // Sticky errors: clear first so a coincident set overrides it.
        if (cs) begin
            if (clr_err)              ovf_d = 1'b0;
            if (clr_err)              unf_d = 1'b0;
            if (wr_en && !op.wr)      ovf_d = 1'b1;
            if (rd_en && !op.rd)      unf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            dout_q  <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            dout_q  <= dout_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Write is suppressed during reset so a request in the reset cycle is
    // aborted rather than landing in memory behind a cleared pointer.
    assign mem_we = rst_n & op.wr;

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[wptr_q[AW-1:0]] <= data_in;
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        if (FWFT != 0) data_out = empty_w ? '0 : head;
        else           data_out = dout_q;
    end

    assign empty        = empty_w;
    assign full         = full_w;
    assign count        = count_q;
    assign almost_empty = (count_q <= AE_THR);
    assign almost_full  = (count_q >= AF_THR);
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_ext.sv
// Directed bench for sync_fifo_ext. Two instances (registered-read and FWFT)
// share one stimulus stream; status outputs are checked on both, data_out
// against the mode-specific expectation.

module tb_sync_fifo_ext;

    localparam int DW = 8;
    localparam int DP = 8;

    logic          clk = 1'b0;
    logic          rst_n, cs, wr_en, rd_en, clr_err;
    logic [DW-1:0] data_in;

    logic [DW-1:0] a_dout, b_dout;
    logic          a_empty, a_full, a_ae, a_af, a_ovf, a_unf;
    logic          b_empty, b_full, b_ae, b_af, b_ovf, b_unf;
    logic [3:0]    a_cnt, b_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sync_fifo_ext #(.DATA_WIDTH(DW), .DEPTH(DP), .FWFT(0), .AF_LEVEL(6), .AE_LEVEL(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .cs(cs), .wr_en(wr_en), .rd_en(rd_en), .clr_err(clr_err),
        .data_in(data_in), .data_out(a_dout), .empty(a_empty), .full(a_full),
        .almost_empty(a_ae), .almost_full(a_af), .count(a_cnt),
        .overflow(a_ovf), .underflow(a_unf));

    sync_fifo_ext #(.DATA_WIDTH(DW), .DEPTH(DP), .FWFT(1), .AF_LEVEL(6), .AE_LEVEL(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .cs(cs), .wr_en(wr_en), .rd_en(rd_en), .clr_err(clr_err),
        .data_in(data_in), .data_out(b_dout), .empty(b_empty), .full(b_full),
        .almost_empty(b_ae), .almost_full(b_af), .count(b_cnt),
        .overflow(b_ovf), .underflow(b_unf));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Status checks on both instances.
    task automatic chk_stat(input string tag, input int cnt, input logic ovf, input logic unf);
        logic e, f, ae, af;
        e  = (cnt == 0);
        f  = (cnt == DP);
        ae = (cnt <= 2);
        af = (cnt >= 6);
        chk({tag, " a.count"}, 32'(a_cnt), 32'(cnt));
        chk({tag, " b.count"}, 32'(b_cnt), 32'(cnt));
        chk({tag, " a.flags"}, {28'd0, a_empty, a_full, a_ae, a_af}, {28'd0, e, f, ae, af});
        chk({tag, " b.flags"}, {28'd0, b_empty, b_full, b_ae, b_af}, {28'd0, e, f, ae, af});
        chk({tag, " a.err"},   {30'd0, a_ovf, a_unf}, {30'd0, ovf, unf});
        chk({tag, " b.err"},   {30'd0, b_ovf, b_unf}, {30'd0, ovf, unf});
    endtask

    task automatic chk_dout(input string tag, input logic [7:0] ea, input logic [7:0] eb);
        chk({tag, " a.dout"}, 32'(a_dout), 32'(ea));
        chk({tag, " b.dout"}, 32'(b_dout), 32'(eb));
    endtask

    task automatic drive(input logic c, input logic w, input logic r, input logic ce, input logic [7:0] d);
        cs = c; wr_en = w; rd_en = r; clr_err = ce; data_in = d;
    endtask

    logic [7:0] seq [9];

    initial begin
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 8'hFF);
        tick();
        tick();
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        tick();

        // Reset state
        chk_stat("reset", 0, 1'b0, 1'b0);
        chk_dout("reset", 8'h00, 8'h00);

        // Fill 0x01..0x08
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 8'(i));
            tick();
            chk_stat($sformatf("fill%0d", i), i, 1'b0, 1'b0);
            chk_dout($sformatf("fill%0d", i), 8'h00, 8'h01);
        end

        // Write into full FIFO -> overflow, nothing stored
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'hEE);
        tick();
        chk_stat("ovf", 8, 1'b1, 1'b0);
        chk_dout("ovf", 8'h00, 8'h01);

        // Full with read+write: count stays 8, head 0x01 leaves, 0xAA enters
        drive(1'b1, 1'b1, 1'b1, 1'b0, 8'hAA);
        tick();
        chk_stat("full_rw", 8, 1'b1, 1'b0);
        chk_dout("full_rw", 8'h01, 8'h02);

        // Drain: 0x02..0x08 then 0xAA
        for (int i = 0; i < 7; i++) seq[i] = 8'(i + 2);
        seq[7] = 8'hAA;
        seq[8] = 8'h00;
        for (int k = 1; k <= 8; k++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
            tick();
            chk_stat($sformatf("drain%0d", k), 8 - k, 1'b1, 1'b0);
            chk_dout($sformatf("drain%0d", k), seq[k-1], seq[k]);
        end

        // Clear overflow
        drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        tick();
        chk_stat("clr_ovf", 0, 1'b0, 1'b0);

        // Empty with read+write: only the write lands, underflow sets
        drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h55);
        tick();
        chk_stat("empty_rw", 1, 1'b0, 1'b1);
        chk_dout("empty_rw", 8'hAA, 8'h55);

        drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        tick();
        chk_stat("rd55", 0, 1'b0, 1'b1);
        chk_dout("rd55", 8'h55, 8'h00);

        // Load three words, then hold cs low with every request asserted
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 8'(8'h30 + i));
            tick();
        end
        chk_stat("load3", 3, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h99);
            tick();
            chk_stat($sformatf("cs0_%0d", i), 3, 1'b0, 1'b1);
            chk_dout($sformatf("cs0_%0d", i), 8'h55, 8'h31);
        end

        drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        tick();
        chk_stat("clr_unf", 3, 1'b0, 1'b0);

        for (int k = 1; k <= 3; k++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
            tick();
            chk_dout($sformatf("rd3_%0d", k), 8'(8'h30 + k), (k < 3) ? 8'(8'h31 + k) : 8'h00);
        end
        chk_stat("rd3_end", 0, 1'b0, 1'b0);

        // Wrap-around: 20 write/read pairs, pointers lap the 8-entry array
        for (int n = 0; n < 20; n++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 8'(8'h10 + n));
            tick();
            chk($sformatf("wrap_w%0d count", n), 32'(a_cnt), 32'd1);
            chk($sformatf("wrap_w%0d b.dout", n), 32'(b_dout), 32'(8'h10 + n));
            drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
            tick();
            chk($sformatf("wrap_r%0d count", n), 32'(a_cnt), 32'd0);
            chk($sformatf("wrap_r%0d a.dout", n), 32'(a_dout), 32'(8'h10 + n));
        end

        // Read of empty with coincident clear: set wins
        drive(1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
        tick();
        chk_stat("set_wins", 0, 1'b0, 1'b1);

        // Five entries then reset with every request active
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
            tick();
        end
        chk_stat("pre_rst", 5, 1'b0, 1'b1);
        chk_dout("pre_rst", 8'h23, 8'h41);

        rst_n = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 8'hCC);
        tick();
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk_stat("mid_rst", 0, 1'b0, 1'b0);
        chk_dout("mid_rst", 8'h00, 8'h00);

        // Fresh write after reset shows through in FWFT mode
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h77);
        tick();
        chk_stat("post_rst", 1, 1'b0, 1'b0);
        chk_dout("post_rst", 8'h00, 8'h77);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
